// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 with UART_RX_PARITY_EN); ports: clk, rst, rx in; data_out/data_valid out with data_ready in; frame_err, parity_err, overrun_err pulses; busy
module uart_rx #(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUDRATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, tick, accept, perr;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign perr = ^{sh, par_bit};
`else
  assign perr = 1'b0;
  assign parity_err = 1'b0;
`endif
  assign busy = state != IDLE;
  assign tick = cnt == (state == START ? CW'(HALF_BIT - 1) : CW'(CLKS_PER_BIT - 1));
  assign accept = state == STOP && tick && rx_s && !perr;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx_s ? IDLE : START;
      START:     state_n = !tick ? START : rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      state_n = tick && bit_cnt == 3'd7 ? PARITY : DATA;
`else
      DATA:      state_n = tick && bit_cnt == 3'd7 ? STOP : DATA;
`endif
      PARITY:    state_n = tick ? STOP : PARITY;
      STOP:      state_n = !tick ? STOP : rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      state       <= state_n;
      cnt         <= (state == IDLE || tick || state_n != state) ? '0 : cnt + 1'b1;
      bit_cnt     <= state == START ? 3'd0 : (state == DATA && tick) ? bit_cnt + 3'd1 : bit_cnt;
      sh          <= (state == DATA && tick) ? {rx_s, sh[7:1]} : sh;
      frame_err   <= state == STOP && tick && !rx_s;
      overrun_err <= accept && data_valid && !data_ready;
      data_valid  <= accept || (data_valid && !data_ready);
      data_out    <= (accept && !(data_valid && !data_ready)) ? sh : data_out;
`ifdef UART_RX_PARITY_EN
      par_bit     <= (state == PARITY && tick) ? rx_s : par_bit;
      parity_err  <= state == STOP && tick && rx_s && perr;
`endif
    end
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 1_000_000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 9600, meaning the line bit rate in bit/s.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port data_out, output, 8 bits: last accepted byte, LSB received first.
REQ-007 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-008 The block SHALL have port data_ready, input, 1 bit: consumer accepts data_out.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 The block SHALL have port overrun_err, output, 1 bit: one-cycle pulse on a dropped byte.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL define CLKS_PER_BIT = CLK_FREQ / BAUDRATE (integer division, 104 at the defaults) and HALF_BIT = CLKS_PER_BIT / 2.
REQ-014 The block SHALL pass rx through a two-flop synchronizer (rx_s) reset to 1, and no logic other than the synchronizer SHALL use raw rx.
REQ-015 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 In IDLE, rx_s = 0 SHALL move the block to START and clear the bit-period counter.
REQ-017 In START, the block SHALL sample rx_s after HALF_BIT cycles: 0 moves to DATA; 1 (glitch) returns to IDLE with no flag.
REQ-018 In DATA, the block SHALL sample rx_s every CLKS_PER_BIT cycles, 8 samples, shifting them into data_out LSB-first via a shift register.
REQ-019 After the 8th data sample, the block SHALL go to PARITY if REQ-030 applies, otherwise to STOP.
REQ-020 In STOP, the block SHALL sample rx_s after CLKS_PER_BIT cycles.
- Sample = 1 and no parity error: byte accepted; next state IDLE.
- Sample = 0: frame_err pulses; byte discarded; next state WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL remain until rx_s = 1, then go to IDLE, so a held-low line (break) never starts a new frame.
REQ-022 An accepted byte SHALL load data_out and set data_valid on the clock edge following the stop-bit sample.
REQ-023 data_valid SHALL clear on a cycle where data_valid and data_ready are both high; data_out is stable while data_valid is high.
REQ-024 On acceptance while data_valid is high and data_ready is low, overrun_err SHALL pulse and data_out SHALL keep the old byte.
REQ-025 On acceptance in the same cycle as a handshake, data_valid SHALL stay high with the new byte and overrun_err SHALL stay low.
REQ-026 All error pulses SHALL be exactly one clk cycle wide.
REQ-027 Reception SHALL run independently of data_ready; the receiver never stalls the line.

Reset
REQ-028 While rst is high, the block SHALL force: state = IDLE; counters = 0; data_out = 8'h00; data_valid, frame_err, parity_err, overrun_err and busy = 0; synchronizer flops = 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no flag, and reception SHALL re-arm on the next falling edge of rx_s after rst drops.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, the block SHALL expect one even-parity bit after the data bits, sampled CLKS_PER_BIT after the 8th data sample.
REQ-031 With UART_RX_PARITY_EN defined, a mismatch SHALL pulse parity_err in the cycle after the stop sample, discard the byte and leave data_valid unchanged.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state SHALL be unreachable, the frame SHALL be 8N1 and parity_err SHALL be tied to 0.

Verification
REQ-033 8N1 byte 8'h23 at 104 clk/bit, data_ready = 0 -> data_valid = 1, data_out = 8'h23, no error pulses; data_ready = 1 for one cycle -> data_valid = 0.
REQ-034 rx low for 30 cycles, then high -> stays IDLE, busy drops, no data_valid, no flags.
REQ-035 Byte 8'h51 with stop bit 0, rx held low for 2 bit times, then byte 8'hA5 -> one frame_err pulse, then data_out = 8'hA5 with data_valid = 1.
REQ-036 Bytes 8'h11 then 8'h22 back-to-back, data_ready = 0 -> data_out = 8'h11, one overrun_err pulse, data_valid stays high.
REQ-037 Macro defined: 8'h07 with parity bit 0 -> one parity_err pulse, no data_valid; 8'h07 with parity bit 1 -> data_out = 8'h07.
REQ-038 rst pulsed during bit 4 of a frame -> all outputs at reset values; the next frame, 8'h3C, is received correctly.
